// File: rtl/lmfe_rank_engine.sv
// Streaming K x K rank filter (median by default) with an internal line buffer.
// Define LMFE_RANK_MODE_EN to add the mode port (median/min/max/25th percentile).
module lmfe_rank_engine #(
    parameter int DW    = 8,
    parameter int K     = 7,
    parameter int IMG_W = 128,
    parameter int IMG_H = 128
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_en,
    input  logic [DW-1:0] Din,
`ifdef LMFE_RANK_MODE_EN
    input  logic [1:0]    mode,
`endif
    output logic          busy,
    output logic          out_valid,
    output logic [DW-1:0] Dout,
    output logic          frame_done
);

    localparam int N  = K * K;
    localparam int CW = $clog2(N + 1);
    localparam int IW = $clog2(N);
    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam logic [CW-1:0] R_MED = CW'((N - 1) / 2);

    typedef enum logic {IDLE, EVAL} state_t;

    state_t          state_q, state_d;
    logic [XW-1:0]   col_q, col_d;
    logic [YW-1:0]   row_q, row_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [CW-1:0]   rank_q, rank_d;
    logic            found_q, found_d;
    logic [DW-1:0]   res_q, res_d;
    logic [DW-1:0]   dout_q, dout_d;
    logic            ov_q, ov_d;
    logic            fd_q, fd_d;
    logic            last_q, last_d;

    logic [DW-1:0]   lb_q [K-1][IMG_W];
    logic [DW-1:0]   win_q [N];

    logic            accept;
    logic            win_done;
    logic            last_px;
    logic [DW-1:0]   cand;
    logic [CW-1:0]   lt;
    logic [CW-1:0]   eq;
    logic            hit;
    logic [CW-1:0]   rank_sel;

    assign busy       = (state_q == EVAL);
    assign out_valid  = ov_q;
    assign Dout       = dout_q;
    assign frame_done = fd_q;

    assign accept   = in_en && !busy;
    assign win_done = accept && (row_q >= YW'(K - 1))
                      && (col_q >= XW'(K - 1));
    assign last_px  = (row_q == YW'(IMG_H - 1))
                      && (col_q == XW'(IMG_W - 1));

`ifdef LMFE_RANK_MODE_EN
    always_comb begin
        rank_sel = R_MED;
        case (mode)
            2'd1:    rank_sel = '0;
            2'd2:    rank_sel = CW'(N - 1);
            2'd3:    rank_sel = CW'((N - 1) / 4);
            default: rank_sel = R_MED;
        endcase
    end
`else
    assign rank_sel = R_MED;
`endif

    // Rank of the current candidate against the whole frozen window
    assign cand = win_q[idx_q];
    always_comb begin
        lt = '0;
        eq = '0;
        for (int i = 0; i < N; i++) begin
            if (win_q[i] < cand)
                lt = lt + CW'(1);
            else if (win_q[i] == cand)
                eq = eq + CW'(1);
        end
    end
    assign hit = (lt <= rank_q) && (rank_q < lt + eq);

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        idx_d   = idx_q;
        rank_d  = rank_q;
        found_d = found_q;
        res_d   = res_q;
        dout_d  = dout_q;
        ov_d    = 1'b0;
        fd_d    = 1'b0;
        last_d  = last_q;
        if (accept) begin
            if (col_q == XW'(IMG_W - 1)) begin
                col_d = '0;
                row_d = last_px ? '0 : row_q + YW'(1);
            end else begin
                col_d = col_q + XW'(1);
            end
        end
        case (state_q)
            IDLE: begin
                if (win_done) begin
                    state_d = EVAL;
                    idx_d   = '0;
                    found_d = 1'b0;
                    rank_d  = rank_sel;
                    last_d  = last_px;
                end
            end
            EVAL: begin
                idx_d = idx_q + IW'(1);
                if (hit && !found_q) begin
                    found_d = 1'b1;
                    res_d   = cand;
                end
                if (idx_q == IW'(N - 1)) begin
                    state_d = IDLE;
                    ov_d    = 1'b1;
                    fd_d    = last_q;
                    dout_d  = found_q ? res_q : cand;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            col_q   <= '0;
            row_q   <= '0;
            idx_q   <= '0;
            rank_q  <= R_MED;
            found_q <= 1'b0;
            res_q   <= '0;
            dout_q  <= '0;
            ov_q    <= 1'b0;
            fd_q    <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            idx_q   <= idx_d;
            rank_q  <= rank_d;
            found_q <= found_d;
            res_q   <= res_d;
            dout_q  <= dout_d;
            ov_q    <= ov_d;
            fd_q    <= fd_d;
            last_q  <= last_d;
        end
    end

    // Storage needs no reset: every entry is written before it is read
    always_ff @(posedge clk) begin
        if (accept) begin
            lb_q[0][col_q] <= Din;
            for (int j = 1; j < K - 1; j++)
                lb_q[j][col_q] <= lb_q[j-1][col_q];
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K - 1; c++)
                    win_q[r*K + c] <= win_q[r*K + c + 1];
                if (r == K - 1)
                    win_q[r*K + K - 1] <= Din;
                else
                    win_q[r*K + K - 1] <= lb_q[K-2-r][col_q];
            end
        end
    end

endmodule

// File: doc/lmfe_rank_engine.md
Name: lmfe_rank_engine

Overview:
- Parametrised successor to the fixed 7x7 local median filter engine.
- Accepts a raster-order pixel stream of an IMG_W x IMG_H frame and buffers the last K-1 rows internally in a register-array line buffer (no external SRAM).
- Forms a K x K window and emits one rank-selected value per complete window; the default rank is the median.
- Sits between the pixel source and the output sink; uses the same in_en/busy/out_valid handshake as the existing engine.

Parameters:
- DW, 8, pixel width in bits.
- K, 7, window edge; odd, legal values 3..9.
- IMG_W, 128, pixels per row; must be >= K.
- IMG_H, 128, rows per frame; must be >= K.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_en  input  1  pixel valid from source.
- Din  input  DW  pixel value.
- busy  output  1  engine cannot accept a pixel this cycle.
- out_valid  output  1  one-cycle pulse: Dout is a valid result.
- Dout  output  DW  selected window value.
- frame_done  output  1  one-cycle pulse with the last out_valid of a frame.
- mode  input  2  rank select; present only with LMFE_RANK_MODE_EN.

Behaviour:
- Reset values: busy=0, out_valid=0, Dout=0, frame_done=0. Row/column counters=0, FSM=IDLE. Line-buffer and window contents are don't-care; they are never read before being written in the current frame.
- Accept rule: a pixel is accepted when in_en=1 && busy=0. Pixels offered while busy=1 are ignored; the source must hold them.
- On accept at (r,c):
  - New column = {lb[K-2][c], ..., lb[0][c], Din}. It shifts into the K-column window register (oldest column drops out).
  - lb[j][c] <= lb[j-1][c]; lb[0][c] <= Din.
  - Column counter increments; at IMG_W-1 it wraps to 0 and the row counter increments.
- Window complete when r >= K-1 && c >= K-1. Only these positions produce output, i.e. (IMG_W-K+1)*(IMG_H-K+1) results per frame, with no border padding.
- FSM IDLE -> EVAL on an accept that completes a window; otherwise it stays in IDLE.
- EVAL lasts exactly K*K cycles. Candidate index i = 0..K*K-1, in window order (row-major, oldest row first).
  - Each cycle: lt = count of window elements < w[i]; eq = count == w[i]. These are combinational, with ceil(log2(K*K+1))-bit counters.
  - w[i] is the hit if lt <= R < lt+eq. The first hit is latched; later hits are ignored.
- Rank R: median, (K*K-1)/2, by default.
- Timing, with the completing pixel accepted in cycle t:
  - busy=1 in cycles t+1 .. t+K*K.
  - In cycle t+K*K+1: busy=0, out_valid=1, Dout=latched value. Dout holds until the next result.
  - FSM returns to IDLE, so a new pixel may be accepted in that same cycle.
- Throughput: one pixel per cycle outside EVAL; K*K+1 cycles per output window.
- Frame wrap: after accepting pixel (IMG_H-1, IMG_W-1), counters return to (0,0). The final result pulses frame_done together with out_valid. The next frame's first pixel may be accepted at the out_valid cycle.
- reset mid-EVAL or mid-frame: immediate return to reset values. No pending result is emitted.

Optional Feature:
- Macro: LMFE_RANK_MODE_EN.
- Defined: adds the mode port, sampled at the accept that completes a window and held through EVAL.
  - 0: median.
  - 1: min (R=0).
  - 2: max (R=K*K-1).
  - 3: 25th percentile (R=(K*K-1)/4).
- Undefined: no mode port; R is fixed at the median. Logic is identical otherwise.

Test Plan:
- K=3, IMG_W=IMG_H=8, every pixel 0x55 streamed with in_en=1 -> exactly 36 out_valid pulses, all Dout=0x55. frame_done accompanies pulse 36. Each result comes 10 cycles after its completing accept.
- K=3, 8x8 frame of 0x10 with a single 0xFF at (3,3) -> all 36 outputs 0x10 (impulse removed). With LMFE_RANK_MODE_EN and mode=2, the 9 windows covering (3,3) give 0xFF and the rest give 0x10.
- K=3, 8x8 ramp Din=8*r+c -> output at window centre (r,c) equals 8*r+c. First result is 9 (window centred at (1,1)).
- Backpressure: hold in_en=1 throughout -> busy high for exactly 9 cycles per window, no pixel lost or duplicated. The output sequence matches a golden model over 2 back-to-back frames.
- Assert reset for 1 cycle during EVAL mid-frame -> busy/out_valid/Dout=0 at once, no stray out_valid. A fresh frame then produces the correct 36 results.
- Default K=7, 128x128 random frame -> 14884 results, bit-exact against a software 7x7 median.
